// File: rtl/formatter_pkg.sv
// rtl/formatter_pkg.sv - shared state encodings, ASCII constants and helpers for the formatter
package formatter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONVERT    = 3'd1,
    EMIT_SIGN  = 3'd2,
    EMIT_DIGIT = 3'd3,
    EMIT_SPACE = 3'd4
  } state_e;

  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_A     = 8'h41;

  // Decimal needs the most digits for a given width; ceil(data*log10(2)) <= data/3+1.
  function automatic int max_digits(input int data);
    return data / 3 + 1;
  endfunction

  localparam int MAX_DIGITS = max_digits(32);

  // Maps a digit value 0..15 onto '0'-'9' / 'A'-'F'.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    if (digit < 4'd10) begin
      return CHAR_ZERO + {4'd0, digit};
    end
    return CHAR_A + {4'd0, digit} - 8'd10;
  endfunction

endpackage

// File: rtl/formatter_div10.sv
// rtl/formatter_div10.sv - sequential restoring divide-by-10, one quotient bit per enabled cycle
module formatter_div10
  import formatter_pkg::*;
#(
  parameter int DATA = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_start,
  input  logic [DATA-1:0] i_dividend,
  output logic [DATA-1:0] o_quot,
  output logic [3:0]      o_rem,
  output logic            o_busy,
  output logic            o_done
);

  localparam int CNT_W = $clog2(DATA + 1);

  logic [DATA-1:0]  quot_q, quot_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       rem_in;
  logic [DATA-1:0]  quot_in;
  logic [4:0]       rem_shift;
  logic             sub_ok;

  // One shift-subtract step; the start cycle already performs step one on the new dividend
  // so that a digit costs exactly DATA cycles. done is a single-cycle pulse.
  always_comb begin
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rem_in  = i_start ? 4'd0 : rem_q;
    quot_in = i_start ? i_dividend : quot_q;
    rem_shift = {rem_in, quot_in[DATA-1]};
    sub_ok    = (rem_shift >= 5'd10);
    if (i_start) begin
      quot_d = {quot_in[DATA-2:0], sub_ok};
      rem_d  = sub_ok ? 4'(rem_shift - 5'd10) : 4'(rem_shift);
      cnt_d  = CNT_W'(DATA - 1);
      busy_d = (DATA > 1);
      done_d = (DATA == 1);
    end else if (busy_q) begin
      quot_d = {quot_in[DATA-2:0], sub_ok};
      rem_d  = sub_ok ? 4'(rem_shift - 5'd10) : 4'(rem_shift);
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider registers; frozen while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (i_en) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign o_quot = quot_q;
  assign o_rem  = rem_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: rtl/formatter.sv
// rtl/formatter.sv - prints one value as signed decimal or unsigned hex characters followed by a space
module formatter
  import formatter_pkg::*;
#(
  parameter int DATA       = 32,
  parameter int CHAR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA-1:0]       i_data,
  input  logic                  i_hex,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [CHAR_WIDTH-1:0] o_char,
  output logic                  o_valid,
  input  logic                  i_next,
  output logic [2:0]            o_state
);

  localparam int MAX_DIG = max_digits(DATA);
  localparam int PTR_W   = $clog2(MAX_DIG + 1);

  state_e          state_q, state_d;
  logic            init_q, init_d;
  logic            hex_q, hex_d;
  logic            neg_q, neg_d;
  logic [DATA-1:0] val_q, val_d;
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [3:0]      stack_q [MAX_DIG];
  logic [3:0]      stack_d [MAX_DIG];

  logic            div_start;
  logic [DATA-1:0] div_dividend;
  logic [DATA-1:0] div_quot;
  logic [3:0]      div_rem;
  logic            div_busy;
  logic            div_done;
  logic [PTR_W-1:0] top_idx;

  formatter_div10 #(.DATA(DATA)) u_div10 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_start    (div_start),
    .i_dividend (div_dividend),
    .o_quot     (div_quot),
    .o_rem      (div_rem),
    .o_busy     (div_busy),
    .o_done     (div_done)
  );

  assign top_idx = sp_q - PTR_W'(1);

  // Next-state, digit stack push/pop and character outputs.
  always_comb begin
    state_d      = state_q;
    init_d       = 1'b1;
    hex_d        = hex_q;
    neg_d        = neg_q;
    val_d        = val_q;
    sp_d         = sp_q;
    stack_d      = stack_q;
    div_start    = 1'b0;
    div_dividend = val_q;
    o_valid      = 1'b0;
    o_char       = '0;
    case (state_q)
      IDLE: begin
        if (init_q && i_valid) begin
          hex_d   = i_hex;
          neg_d   = !i_hex && i_data[DATA-1];
          val_d   = (!i_hex && i_data[DATA-1]) ? -i_data : i_data;
          sp_d    = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (hex_q) begin
          stack_d[sp_q] = val_q[3:0];
          sp_d          = sp_q + PTR_W'(1);
          val_d         = val_q >> 4;
          if (val_q[DATA-1:4] == '0) begin
            state_d = EMIT_DIGIT;
          end
        end else if (div_done) begin
          stack_d[sp_q] = div_rem;
          sp_d          = sp_q + PTR_W'(1);
          if (div_quot == '0) begin
            state_d = neg_q ? EMIT_SIGN : EMIT_DIGIT;
          end else begin
            div_start    = 1'b1;
            div_dividend = div_quot;
          end
        end else if (!div_busy) begin
          div_start = 1'b1;
        end
      end
      EMIT_SIGN: begin
        o_valid = 1'b1;
        o_char  = CHAR_WIDTH'(CHAR_MINUS);
        if (i_next) begin
          state_d = EMIT_DIGIT;
        end
      end
      EMIT_DIGIT: begin
        o_valid = 1'b1;
        o_char  = CHAR_WIDTH'(digit_to_ascii(stack_q[top_idx]));
        if (i_next) begin
          sp_d = top_idx;
          if (sp_q == PTR_W'(1)) begin
            state_d = EMIT_SPACE;
          end
        end
      end
      EMIT_SPACE: begin
        o_valid = 1'b1;
        o_char  = CHAR_WIDTH'(CHAR_SPACE);
        if (i_next) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; everything freezes while disabled, reset aborts any value in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      val_q   <= '0;
      sp_q    <= '0;
      for (int i = 0; i < MAX_DIG; i++) begin
        stack_q[i] <= '0;
      end
    end else if (i_en) begin
      state_q <= state_d;
      init_q  <= init_d;
      hex_q   <= hex_d;
      neg_q   <= neg_d;
      val_q   <= val_d;
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end

  assign o_ready = (state_q == IDLE) && init_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_formatter.sv
// tb/tb_formatter.sv - randomized self-checking bench for formatter against a string-level model
module tb_formatter;

  localparam int DATA = 32;
  localparam int CW   = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_en = 1'b1;
  logic [DATA-1:0] i_data = '0;
  logic          i_hex = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_next = 1'b0;
  logic          o_ready;
  logic [CW-1:0] o_char;
  logic          o_valid;
  logic [2:0]    o_state;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  formatter #(.DATA(DATA), .CHAR_WIDTH(CW)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_data  (i_data),
    .i_hex   (i_hex),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_char  (o_char),
    .o_valid (o_valid),
    .i_next  (i_next),
    .o_state (o_state)
  );

  function automatic string model(input logic [31:0] d, input bit hex);
    string digs;
    string s;
    longint mag;
    longint base;
    bit neg;
    int k;
    digs = "0123456789ABCDEF";
    s = "";
    base = hex ? 16 : 10;
    neg = !hex && d[31];
    mag = neg ? ((longint'(1) << 32) - longint'(d)) : longint'(d);
    do begin
      k = int'(mag % base);
      s = {digs.substr(k, k), s};
      mag = mag / base;
    end while (mag != 0);
    if (neg) s = {"-", s};
    return {s, " "};
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_value(input logic [31:0] d, input bit hex, input bit rnd_next,
                           input bit noise, input bit rnd_en, input int hold, input string name);
    string exp;
    int nd, cyc, idx, lat;
    bit took;
    exp = model(d, hex);
    nd = exp.len() - 1 - ((exp[0] == "-") ? 1 : 0);
    lat = hex ? nd : nd * DATA + 1;
    i_en = 1'b1; i_next = 1'b0; i_valid = 1'b0;
    cyc = 0;
    while (!o_ready && cyc < 100) begin tick; cyc++; end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: o_ready=%b required 1", name, o_ready);
      return;
    end
    i_data = d; i_hex = hex; i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0 || o_state !== 3'd1) begin
      errors++;
      $display("FAIL %s accept: o_ready=%b o_state=%0d required 0 and 1", name, o_ready, o_state);
    end
    cyc = 0;
    while (!o_valid && cyc < 2000) begin
      if (noise) begin i_valid = 1'($urandom % 2); i_data = $urandom; i_hex = 1'($urandom % 2); end
      if (rnd_en) i_en = ($urandom % 4) != 0;
      tick;
      cyc++;
    end
    i_en = 1'b1;
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s first_valid_timeout: o_valid=%b required 1", name, o_valid);
      return;
    end
    if (!rnd_en) begin
      checks++;
      if (cyc != lat) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles required %0d", name, cyc, lat);
      end
    end
    for (int h = 0; h < hold; h++) begin
      i_next = 1'b0;
      tick;
      checks++;
      if (o_valid !== 1'b1 || o_char !== exp[0]) begin
        errors++;
        $display("FAIL %s hold: o_valid=%b o_char=%h required 1 and %h", name, o_valid, o_char, exp[0]);
      end
    end
    idx = 0; cyc = 0;
    while (idx < exp.len() && cyc < 5000) begin
      i_next = rnd_next ? (($urandom % 3) != 0) : 1'b1;
      i_en = rnd_en ? (($urandom % 4) != 0) : 1'b1;
      if (noise) begin
        i_valid = (idx < exp.len() - 1) ? 1'($urandom % 2) : 1'b0;
        i_data = $urandom;
        i_hex = 1'($urandom % 2);
      end
      took = o_valid && i_next && i_en;
      if (took) begin
        checks++;
        if (o_char !== exp[idx]) begin
          errors++;
          $display("FAIL %s char[%0d]: o_char=%h required %h", name, idx, o_char, exp[idx]);
        end
        idx++;
      end
      tick;
      cyc++;
    end
    i_next = 1'b0; i_valid = 1'b0; i_en = 1'b1;
    checks++;
    if (idx != exp.len()) begin
      errors++;
      $display("FAIL %s char_count: got %0d chars required %0d", name, idx, exp.len());
    end
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: o_ready=%b o_valid=%b required 1 and 0", name, o_ready, o_valid);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_next = 1'b0;
    tick; tick;
    checks++;
    if (o_valid !== 1'b0 || o_char !== 8'h00 || o_ready !== 1'b0 || o_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b char=%h ready=%b state=%0d required 0 00 0 0",
               o_valid, o_char, o_ready, o_state);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: o_ready=%b required 0", o_ready);
    end
    tick;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: o_ready=%b required 1", o_ready);
    end
  endtask

  task automatic test_directed;
    run_value(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "dec_zero");
    run_value(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, "dec_1234");
    run_value(32'hFFFFFFFB, 1'b0, 1'b0, 1'b0, 1'b0, 0, "dec_neg5");
    run_value(32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 0, "dec_min");
    run_value(32'h00ABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 5, "hex_abcdef_bp");
    run_value(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, "hex_ffffffff");
    run_value(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "hex_zero");
    run_value(32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, "dec_max");
  endtask

  task automatic test_reset_mid;
    int cyc;
    run_value(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "pre_mid");
    i_data = 32'h80000000; i_hex = 1'b0; i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    i_next = 1'b1;
    cyc = 0;
    while (o_state !== 3'd3 && cyc < 2000) begin tick; cyc++; end
    checks++;
    if (o_state !== 3'd3) begin
      errors++;
      $display("FAIL mid_reach_digit: o_state=%0d required 3", o_state);
    end
    tick; tick;
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_state !== 3'd0 || o_char !== 8'h00 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: valid=%b state=%0d char=%h ready=%b required 0 0 00 0",
               o_valid, o_state, o_char, o_ready);
    end
    tick;
    i_rst = 1'b0;
    tick;
    i_next = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_idle: valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
    run_value(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, "after_reset_1234");
  endtask

  task automatic test_ignore_and_enable;
    run_value(32'd7654321, 1'b0, 1'b1, 1'b1, 1'b0, 0, "ignore_valid");
    run_value(32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 0, "ignore_valid_hex");
    run_value(32'hFFFF8000, 1'b0, 1'b1, 1'b0, 1'b1, 0, "enable_gaps");
    run_value(32'h0BADF00D, 1'b1, 1'b1, 1'b0, 1'b1, 3, "enable_gaps_hex");
  endtask

  task automatic test_random;
    logic [31:0] d;
    int sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom % 4;
      case (sel)
        0: d = $urandom;
        1: d = $urandom % 100;
        2: d = -($urandom % 1000);
        default: d = $urandom >> ($urandom % 32);
      endcase
      run_value(d, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                int'($urandom % 3), "random");
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++) begin
      run_value(32'd9 + 32'(n) * 32'd1111, n[0], 1'b0, 1'b0, 1'b0, 0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_ignore_and_enable();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
